// File: rtl/vector_alu_hs.sv
// vector_alu_hs - packed-vector ALU with valid/ready handshakes.
//
// Operands are LANES lanes of LANE_W bits, lane 0 in the MSBs.
// Single-cycle ops are registered on acceptance. VDOT and VSCALE step
// through one shared LANE_W x LANE_W multiplier, one lane per cycle.
// The result, flags and err are held until the consumer takes them.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation request handshake
//   op, opa, opb         opcode and packed operands, captured on acceptance
//   out_valid/out_ready  result handshake
//   result, flags, err   result, {N,Z,C,V}, illegal-opcode marker
//
// Build option: define VECTOR_ALU_SATURATE_EN to saturate VADD/VSUB/VSCALE
// lanes. Carry and overflow flags still report the unsaturated condition.
module vector_alu_hs #(
  parameter int LANES  = 3,
  parameter int LANE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              op,
  input  logic [LANES*LANE_W-1:0] opa,
  input  logic [LANES*LANE_W-1:0] opb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [3:0]              flags,
  output logic                    err
);

  localparam int W  = LANES * LANE_W;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] OP_VADD   = 4'b0000;
  localparam logic [3:0] OP_VDOT   = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_CMP    = 4'b0100;
  localparam logic [3:0] OP_VSCALE = 4'b0101;
  localparam logic [3:0] OP_MUL    = 4'b0110;
  localparam logic [3:0] OP_CONCAT = 4'b0111;
  localparam logic [3:0] OP_VSUB   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    HOLD
  } state_t;

  function automatic logic [LANE_W-1:0] get_lane(input logic [W-1:0] v,
                                                 input int unsigned i);
    return v[W-1-i*LANE_W -: LANE_W];
  endfunction

  function automatic logic is_iter_op(input logic [3:0] o);
    return (o == OP_VDOT) || (o == OP_VSCALE);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_valid;
  logic [W-1:0]        r_result;
  logic [3:0]          r_flags;
  logic                r_err;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [3:0]          r_op;
  logic [W-1:0]        r_acc;
  logic [CW-1:0]       r_cnt;

  logic                w_accept;
  logic                w_last;
  logic [3:0]          w_op_cur;
  logic [W-1:0]        w_src_a;
  logic [W-1:0]        w_src_b;
  logic [LANE_W-1:0]   w_mul_a;
  logic [LANE_W-1:0]   w_mul_b;
  logic [2*LANE_W-1:0] w_prod;
  logic [LANE_W-1:0]   w_sc_lane;
  logic [W-1:0]        w_acc_base;
  logic [W-1:0]        w_acc_next;
  logic [3:0]          w_it_flags;

  logic [W:0]          w_add_full;
  logic [W:0]          w_sub_full;
  logic [W-1:0]        w_mul_lo;
  logic [LANE_W:0]     w_l_tmp;
  logic [W-1:0]        w_sc_result;
  logic                w_sc_c;
  logic                w_sc_v;
  logic                w_sc_err;
  logic [3:0]          w_sc_flags;

  // The FSM never sits in HOLD without out_valid, so HOLD accepts a new op
  // exactly when the held result is being taken; only ITER blocks input.
  assign in_ready  = (r_state != ITER) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == ITER) && (r_cnt == CW'(LANES - 1));

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign err       = r_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, HOLD: begin
        if (w_accept)
          w_state_nxt = is_iter_op(op) ? ITER : HOLD;
        else if (r_state == HOLD && out_ready)
          w_state_nxt = IDLE;
      end
      ITER: begin
        if (w_last) w_state_nxt = HOLD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------ shared multiplier
  // Lane 0 is multiplied in the acceptance cycle straight from the input
  // operands (r_cnt is 0 outside ITER), so ITER covers lanes 1..LANES-1
  // and the result lands LANES cycles after acceptance.
  assign w_op_cur = (r_state == ITER) ? r_op : op;
  assign w_src_a  = (r_state == ITER) ? r_a  : opa;
  assign w_src_b  = (r_state == ITER) ? r_b  : opb;
  assign w_mul_a  = get_lane(w_src_a, 32'(r_cnt));
  assign w_mul_b  = (w_op_cur == OP_VSCALE) ? get_lane(w_src_b, LANES - 1)
                                            : get_lane(w_src_b, 32'(r_cnt));
  assign w_prod   = {{LANE_W{1'b0}}, w_mul_a} * {{LANE_W{1'b0}}, w_mul_b};

  always_comb begin
    w_sc_lane = w_prod[LANE_W-1:0];
`ifdef VECTOR_ALU_SATURATE_EN
    if (|w_prod[2*LANE_W-1:LANE_W]) w_sc_lane = '1;
`endif
  end

  always_comb begin
    w_acc_base = (r_state == ITER) ? r_acc : '0;
    w_acc_next = w_acc_base;
    if (w_op_cur == OP_VDOT) begin
      w_acc_next = w_acc_base + W'(w_prod);
    end else begin
      for (int unsigned i = 0; i < LANES; i++)
        if (i == 32'(r_cnt)) w_acc_next[W-1-i*LANE_W -: LANE_W] = w_sc_lane;
    end
  end

  assign w_it_flags = {w_acc_next[W-1], ~|w_acc_next, 2'b00};

  // ---------------------------------------------- single-cycle datapath
  assign w_add_full = {1'b0, opa} + {1'b0, opb};
  assign w_sub_full = {1'b0, opa} - {1'b0, opb};
  assign w_mul_lo   = opa * opb;

  always_comb begin
    w_sc_result = '0;
    w_sc_c      = 1'b0;
    w_sc_v      = 1'b0;
    w_sc_err    = 1'b0;
    w_l_tmp     = '0;
    case (op)
      OP_VADD: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          w_l_tmp = {1'b0, get_lane(opa, i)} + {1'b0, get_lane(opb, i)};
          w_sc_c  = w_sc_c | w_l_tmp[LANE_W];
          w_sc_result[W-1-i*LANE_W -: LANE_W] = w_l_tmp[LANE_W-1:0];
`ifdef VECTOR_ALU_SATURATE_EN
          if (w_l_tmp[LANE_W]) w_sc_result[W-1-i*LANE_W -: LANE_W] = '1;
`endif
        end
        w_sc_v = w_sc_c;
      end
      OP_VSUB: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          w_l_tmp = {1'b0, get_lane(opa, i)} - {1'b0, get_lane(opb, i)};
          w_sc_c  = w_sc_c | w_l_tmp[LANE_W];
          w_sc_result[W-1-i*LANE_W -: LANE_W] = w_l_tmp[LANE_W-1:0];
`ifdef VECTOR_ALU_SATURATE_EN
          if (w_l_tmp[LANE_W]) w_sc_result[W-1-i*LANE_W -: LANE_W] = '0;
`endif
        end
        w_sc_v = w_sc_c;
      end
      OP_SUB, OP_CMP: begin
        w_sc_result = w_sub_full[W-1:0];
        w_sc_c      = ~w_sub_full[W];
        w_sc_v      = (opa[W-1] != opb[W-1]) && (w_sub_full[W-1] != opa[W-1]);
      end
      OP_ADD: begin
        w_sc_result = w_add_full[W-1:0];
        w_sc_c      = w_add_full[W];
        w_sc_v      = (opa[W-1] == opb[W-1]) && (w_add_full[W-1] != opa[W-1]);
      end
      OP_MUL: begin
        w_sc_result = w_mul_lo;
      end
      OP_CONCAT: begin
        w_sc_result[2*LANE_W-1 -: LANE_W] = opa[LANE_W-1:0];
        w_sc_result[LANE_W-1:0]           = opb[LANE_W-1:0];
      end
      OP_VDOT, OP_VSCALE: begin
        w_sc_result = '0;
      end
      default: begin
        w_sc_result = '1;
        w_sc_err    = 1'b1;
      end
    endcase
  end

  assign w_sc_flags = w_sc_err ? 4'b0000
                    : {w_sc_result[W-1], ~|w_sc_result, w_sc_c, w_sc_v};

  // -------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_accept) begin
      r_a  <= opa;
      r_b  <= opb;
      r_op <= op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept && is_iter_op(op)) begin
      r_acc <= w_acc_next;
      r_cnt <= CW'(1);
    end else if (r_state == ITER) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept && !is_iter_op(op)) begin
      r_out_valid <= 1'b1;
      r_result    <= w_sc_result;
      r_flags     <= w_sc_flags;
      r_err       <= w_sc_err;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
      r_result    <= w_acc_next;
      r_flags     <= w_it_flags;
      r_err       <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_alu_hs.sv
module tb_vector_alu_hs;

  localparam int LANES  = 3;
  localparam int LANE_W = 16;
  localparam int W      = LANES * LANE_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  vector_alu_hs #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         er;
    int           lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    int  lat;
    logic busy_ok;
    @(posedge clk); #1;
    op = v.op; opa = v.a; opb = v.b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({v.name, "_accept"}, 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, "_result"}, 64'(result), 64'(v.res));
    chk({v.name, "_flags"}, 64'(flags), 64'(v.fl));
    chk({v.name, "_err"}, 64'(err), 64'(v.er));
    if (v.lat > 1) chk({v.name, "_busy"}, 64'(busy_ok), 64'(1'b1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, "_drained"}, 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    vecs[0]  = '{"vadd",      4'h0, 48'h0001_0002_0003, 48'h000A_0014_001E, 48'h000B_0016_0021, 4'b0000, 1'b0, 1};
    vecs[1]  = '{"vdot",      4'h1, 48'h0002_0003_0004, 48'h0005_0006_0007, 48'h0000_0000_0038, 4'b0000, 1'b0, 3};
    vecs[2]  = '{"sub_eq",    4'h2, 48'h0000_0000_0005, 48'h0000_0000_0005, 48'h0000_0000_0000, 4'b0110, 1'b0, 1};
    vecs[3]  = '{"cmp_lt",    4'h4, 48'h0000_0000_0003, 48'h0000_0000_0005, 48'hFFFF_FFFF_FFFE, 4'b1000, 1'b0, 1};
    vecs[4]  = '{"add_ovf",   4'h3, 48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 48'h8000_0000_0000, 4'b1001, 1'b0, 1};
    vecs[5]  = '{"add_cry",   4'h3, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0002, 48'h0000_0000_0001, 4'b0010, 1'b0, 1};
`ifdef VECTOR_ALU_SATURATE_EN
    vecs[6]  = '{"vsub_brw",  4'h8, 48'h0005_0000_0009, 48'h0003_0001_0009, 48'h0002_0000_0000, 4'b0011, 1'b0, 1};
    vecs[7]  = '{"vadd_lane", 4'h0, 48'hFFF0_0000_0000, 48'h0020_0000_0000, 48'hFFFF_0000_0000, 4'b1011, 1'b0, 1};
    vecs[8]  = '{"vscale_ov", 4'h5, 48'h8000_0001_0000, 48'h0000_0000_0004, 48'hFFFF_0004_0000, 4'b1000, 1'b0, 3};
`else
    vecs[6]  = '{"vsub_brw",  4'h8, 48'h0005_0000_0009, 48'h0003_0001_0009, 48'h0002_FFFF_0000, 4'b0011, 1'b0, 1};
    vecs[7]  = '{"vadd_lane", 4'h0, 48'hFFF0_0000_0000, 48'h0020_0000_0000, 48'h0010_0000_0000, 4'b0011, 1'b0, 1};
    vecs[8]  = '{"vscale_ov", 4'h5, 48'h8000_0001_0000, 48'h0000_0000_0004, 48'h0000_0004_0000, 4'b0000, 1'b0, 3};
`endif
    vecs[9]  = '{"vscale",    4'h5, 48'h0002_0100_0007, 48'h1234_5678_0003, 48'h0006_0300_0015, 4'b0000, 1'b0, 3};
    vecs[10] = '{"mul",       4'h6, 48'h0000_0001_0000, 48'h0000_0001_0003, 48'h0001_0003_0000, 4'b0000, 1'b0, 1};
    vecs[11] = '{"concat",    4'h7, 48'h1111_2222_3333, 48'h4444_5555_6666, 48'h0000_3333_6666, 4'b0000, 1'b0, 1};
    vecs[12] = '{"vadd_zero", 4'h0, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'h0000_0000_0000, 4'b0100, 1'b0, 1};
    vecs[13] = '{"illegal_f", 4'hF, 48'h1234_5678_9ABC, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 4'b0000, 1'b1, 1};
    vecs[14] = '{"vdot_big",  4'h1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0002_FFFA_0003, 4'b0000, 1'b0, 3};
    vecs[15] = '{"illegal_9", 4'h9, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 4'b0000, 1'b1, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; opa = '0; opb = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst_err", 64'(err), 64'(1'b0));
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Output held under backpressure, then back-to-back acceptance.
    @(posedge clk); #1;
    op = 4'h0; opa = 48'h0001_0001_0001; opb = 48'h0002_0002_0002;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 4'h3; opa = 48'h0000_0000_0100; opb = 48'h0000_0000_0023;
    chk("hold_valid", 64'(out_valid), 64'(1'b1));
    for (int k = 0; k < 4; k++) begin
      chk("hold_result", 64'(result), 64'(48'h0003_0003_0003));
      chk("hold_in_ready", 64'(in_ready), 64'(1'b0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'(1'b1));
    chk("b2b_result", 64'(result), 64'(48'h0000_0000_0123));
    chk("b2b_flags", 64'(flags), 64'(4'b0000));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_drained", 64'(out_valid), 64'(1'b0));

    // Reset asserted in the second ITER cycle of a VDOT.
    @(posedge clk); #1;
    op = 4'h1; opa = 48'h0002_0003_0004; opb = 48'h0005_0006_0007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(1'b0));
    chk("abort_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(out_valid), 64'(1'b0));
    chk("abort_result_zero", 64'(result), 64'(0));
    run_vec('{"vdot_ones", 4'h1, 48'h0001_0001_0001, 48'h0001_0001_0001,
              48'h0000_0000_0003, 4'b0000, 1'b0, 3});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
